// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and small constant helpers used by the host-side PS/2 blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_FIRST,
    SHIFT,
    ACK,
    WAIT_IDLE,
    FAIL
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-FF synchronizer, FILTER_LEN-sample glitch filter and a
// one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Lines idle high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_fall <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync;
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 byte transmitter with start/busy/done handshake.
// Optional PS2_TX_RETRY_EN: up to 2 automatic retries before tx_error.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned TW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT) + 1);
  localparam logic [TW-1:0] INH_END   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_END = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] XFER_END  = TW'(XFER_TIMEOUT - 1);

  ps2_state_e    r_state, w_state_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_par, w_par_nxt;
  logic [3:0]    r_bitcnt, w_bitcnt_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_ack, w_ack_nxt;
  logic          r_clk_oe, w_clk_oe_nxt;
  logic          r_dat_oe, w_dat_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_error, w_error_nxt;
  logic          r_dat_meta, r_dat_sync;
  logic          w_clk_level, w_clk_fall;
  logic          w_fail;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    r_retry, w_retry_nxt;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clock   (clock),
    .reset   (reset),
    .i_raw   (ps2_clk_in),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  // Data only needs synchronizing: it is sampled well inside a clock phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_dat_meta <= ps2_dat_in;
      r_dat_sync <= r_dat_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_bitcnt <= '0;
      r_timer  <= '0;
      r_ack    <= 1'b1;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      r_retry  <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_data   <= w_data_nxt;
      r_par    <= w_par_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_timer  <= w_timer_nxt;
      r_ack    <= w_ack_nxt;
      r_clk_oe <= w_clk_oe_nxt;
      r_dat_oe <= w_dat_oe_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
`ifdef PS2_TX_RETRY_EN
      r_retry  <= w_retry_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_par_nxt    = r_par;
    w_bitcnt_nxt = r_bitcnt;
    w_timer_nxt  = (&r_timer) ? r_timer : r_timer + 1'b1;
    w_ack_nxt    = r_ack;
    w_clk_oe_nxt = r_clk_oe;
    w_dat_oe_nxt = r_dat_oe;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;
    w_fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    w_retry_nxt  = r_retry;
`endif

    case (r_state)
      IDLE: begin
        // A pulse cycle still belongs to the previous transfer.
        if (tx_start && !r_done && !r_error) begin
          w_data_nxt   = tx_data;
          w_par_nxt    = odd_parity(tx_data);
          w_busy_nxt   = 1'b1;
          w_clk_oe_nxt = 1'b1;
          w_dat_oe_nxt = 1'b0;
          w_timer_nxt  = '0;
          w_state_nxt  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          w_retry_nxt  = '0;
`endif
        end
      end
      INHIBIT: begin
        if (r_dat_oe) begin
          w_clk_oe_nxt = 1'b0;
          w_timer_nxt  = '0;
          w_state_nxt  = WAIT_FIRST;
        end else if (r_timer == INH_END) begin
          w_dat_oe_nxt = 1'b1;
        end
      end
      WAIT_FIRST: begin
        if (w_clk_fall) begin
          w_dat_oe_nxt = ~r_data[0];
          w_bitcnt_nxt = 4'd1;
          w_timer_nxt  = '0;
          w_state_nxt  = SHIFT;
        end else if (r_timer == START_END) begin
          w_fail = 1'b1;
        end
      end
      SHIFT: begin
        // r_bitcnt holds edges seen so far; this edge is number r_bitcnt+1.
        if (r_timer == XFER_END) begin
          w_fail = 1'b1;
        end else if (w_clk_fall) begin
          w_bitcnt_nxt = r_bitcnt + 4'd1;
          if (r_bitcnt <= 4'd7) begin
            w_dat_oe_nxt = ~r_data[r_bitcnt[2:0]];
          end else if (r_bitcnt == 4'd8) begin
            w_dat_oe_nxt = ~r_par;
          end else if (r_bitcnt == 4'd9) begin
            w_dat_oe_nxt = 1'b0;
          end else begin
            w_ack_nxt   = r_dat_sync;
            w_state_nxt = ACK;
          end
        end
      end
      ACK: begin
        if (r_timer == XFER_END || r_ack) begin
          w_fail = 1'b1;
        end else begin
          w_state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (r_timer == XFER_END) begin
          w_fail = 1'b1;
        end else if (w_clk_level && r_dat_sync) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      FAIL: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_fail) begin
      w_clk_oe_nxt = 1'b0;
      w_dat_oe_nxt = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (r_retry != 2'd2) begin
        w_retry_nxt  = r_retry + 2'd1;
        w_clk_oe_nxt = 1'b1;
        w_timer_nxt  = '0;
        w_state_nxt  = INHIBIT;
      end else begin
        w_error_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = FAIL;
      end
`else
      w_error_nxt = 1'b1;
      w_busy_nxt  = 1'b0;
      w_state_nxt = FAIL;
`endif
    end
  end

  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign tx_error   = r_error;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: wired-AND PS/2 device model clocking frames, with the
// expected frame bits and outcomes derived from the PS/2 framing rules.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int STO  = 2000;
  localparam int XTO  = 3000;
  localparam int FL   = 8;
  localparam int HALF = 40;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .XFER_TIMEOUT   (XTO),
    .FILTER_LEN     (FL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 clock = ~clock;

  always @(negedge clock) begin
    if (tx_done) n_done++;
    if (tx_error) n_err++;
    if (tx_done && tx_error) n_both++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Device-observed DAT after edges 1..10: d0..d7, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2) == 0, d};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  // mode 0: ACK, 1: no ACK, 2: never clocks. reset_at>0 resets after that edge.
  task automatic dev_attempt(input int mode, input bit glitch, input int reset_at,
                             input bit chk_inh, output logic [9:0] bits, output int cnt);
    int w;
    bits = '0;
    cnt  = 0;
    w = 0;
    while (!ps2_clk_oe && w < 20) begin @(negedge clock); w++; end
    chk("inhibit_seen", 32'(ps2_clk_oe), 1);
    if (!ps2_clk_oe) return;
    w = 0;
    while (ps2_clk_oe && w < INH + 20) begin @(negedge clock); w++; end
    chk("release_seen", 32'(ps2_clk_oe), 0);
    if (chk_inh) chk("inhibit_len", 32'(w), INH + 1);
    chk("start_bit", 32'(ps2_dat_oe), 1);
    if (mode == 2) begin
      while (!(tx_error || ps2_clk_oe) && cnt < STO + 20) begin @(negedge clock); cnt++; end
      return;
    end
    cyc(100);
    for (int e = 1; e <= 11; e++) begin
      dev_clk_low = 1'b1;
      cyc(HALF);
      if (e == reset_at) begin
        chk("dat_oe_pre_reset", 32'(ps2_dat_oe), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("oe_on_reset", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
        chk("busy_on_reset", 32'(tx_busy), 0);
        dev_clk_low = 1'b0;
        cyc(2);
        reset = 1'b0;
        return;
      end
      dev_clk_low = 1'b0;
      if (e <= 10) bits[e-1] = ps2_dat_in;
      if (e == 10 && mode == 0) dev_dat_low = 1'b1;
      if (glitch && e == 3) begin
        cyc(HALF / 2);
        dev_clk_low = 1'b1;
        cyc(1);
        dev_clk_low = 1'b0;
        cyc(HALF - HALF / 2 - 1);
      end else begin
        cyc(HALF);
      end
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic run_tx(input logic [7:0] d, input int mode, input bit glitch,
                        input bit extra, input bit start_on_pulse);
    logic [9:0] bits;
    int cnt, nd, ne, natt, w;
    nd   = n_done;
    ne   = n_err;
    natt = (mode == 0) ? 1 : ATTEMPTS;
    start_tx(d);
    chk("busy_set", 32'(tx_busy), 1);
    if (extra) begin
      tx_data  = ~d;
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
    end
    for (int a = 0; a < natt; a++) begin
      dev_attempt(mode, glitch, 0, (a == 0) && !extra, bits, cnt);
      if (mode == 2) chk("start_timeout", 32'(cnt), STO);
      else chk("frame_bits", 32'(bits), 32'(ref_frame(d)));
      if (a < natt - 1) chk("busy_retry", 32'(tx_busy), 1);
    end
    w = 0;
    while (tx_busy && w < XTO + 100) begin @(negedge clock); w++; end
    if (start_on_pulse) begin
      chk("done_with_busy_drop", 32'(tx_done), 1);
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
    end
    cyc(3);
    chk("done_cnt", 32'(n_done - nd), (mode == 0) ? 1 : 0);
    chk("err_cnt", 32'(n_err - ne), (mode != 0) ? 1 : 0);
    chk("busy_clr", 32'(tx_busy), 0);
    chk("oe_idle", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
  endtask

  initial begin
    logic [9:0] bits;
    int cnt, nd, ne, mode;
    logic [7:0] d;

    reset = 1'b1;
    cyc(5);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_error", 32'(tx_error), 0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rst_dat_oe", 32'(ps2_dat_oe), 0);
    reset = 1'b0;
    cyc(20);

    run_tx(CMD_SET_LED, 0, 1'b0, 1'b0, 1'b0);
    run_tx(8'h01, 0, 1'b0, 1'b0, 1'b0);
    run_tx(CMD_RESET, 0, 1'b0, 1'b0, 1'b1);
    run_tx(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    run_tx(8'h3C, 2, 1'b0, 1'b0, 1'b0);
    run_tx(8'h96, 1, 1'b0, 1'b0, 1'b0);

    nd = n_done;
    ne = n_err;
    start_tx(CMD_SET_LED);
    dev_attempt(0, 1'b0, 5, 1'b1, bits, cnt);
    cyc(30);
    chk("reset_no_done", 32'(n_done - nd), 0);
    chk("reset_no_err", 32'(n_err - ne), 0);
    chk("reset_idle_busy", 32'(tx_busy), 0);
    run_tx(CMD_ENABLE, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      d    = 8'($urandom);
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_tx(d, mode, 1'b0, 1'b0, 1'b0);
    end

    chk("never_both", 32'(n_both), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
